// File: rtl/perceptron_trainer.sv
// Training sequencer for a perceptron stage: stores a labelled sample set, presents it
// epoch by epoch, counts misclassifications and stops on convergence or the epoch limit.
module perceptron_trainer #(
   parameter int ADDR_W      = 3,
   parameter int HOLD_CYCLES = 2,
   parameter int MAX_EPOCHS  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [3:0]        load_in1,
   input  logic [3:0]        load_in2,
   input  logic [6:0]        load_in3,
   input  logic              load_label,
   input  logic              start,
   input  logic              p_out,
   output logic [3:0]        p_in1,
   output logic [3:0]        p_in2,
   output logic [6:0]        p_in3,
   output logic              p_desired,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [7:0]        epoch_count,
   output logic [ADDR_W:0]   last_errors
);
   localparam int NUM_SAMPLES = 2 ** ADDR_W;
   localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam logic [7:0]        EPOCH_MAX = 8'(MAX_EPOCHS);
   localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W + 1)'(NUM_SAMPLES);
   localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, PRESENT, EPOCH_END, DONE} state_t;

   state_t            state, state_next;
   logic [15:0]       mem [NUM_SAMPLES];
   logic [ADDR_W-1:0] idx;
   logic [3:0]        hold;
   logic [ADDR_W:0]   err;
   logic [15:0]       cur;
   logic              idle_like, load_ok, hold_end, last_idx, mismatch, epoch_limit;

   // Sample word layout: {in1, in2, in3, label}
   assign cur         = mem[idx];
   assign idle_like   = (state == IDLE) || (state == DONE);
   assign load_ok     = load_valid && idle_like;
   assign hold_end    = (hold == HOLD_LAST);
   assign last_idx    = (idx == {ADDR_W{1'b1}});
   assign mismatch    = (p_out != cur[0]);
   assign epoch_limit = ((epoch_count + 8'd1) == EPOCH_MAX);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      p_in1      = '0;
      p_in2      = '0;
      p_in3      = '0;
      p_desired  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = PRESENT;
         end
         PRESENT: begin
            busy = 1'b1;
            {p_in1, p_in2, p_in3, p_desired} = cur;
            if (hold_end && last_idx) state_next = EPOCH_END;
         end
         EPOCH_END: begin
            busy = 1'b1;
            {p_in1, p_in2, p_in3, p_desired} = cur;
            if (err == '0 || epoch_limit) state_next = DONE;
            else                          state_next = PRESENT;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = PRESENT;
         end
      endcase
   end

   // Written before the presentation reads it, so a write alongside start is seen.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SAMPLES; i++) mem[i] <= '0;
      end else if (load_ok) begin
         mem[load_addr] <= {load_in1, load_in2, load_in3, load_label};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx         <= '0;
         hold        <= '0;
         err         <= '0;
         epoch_count <= '0;
         last_errors <= '0;
         converged   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx         <= '0;
                  hold        <= '0;
                  err         <= '0;
                  epoch_count <= '0;
                  last_errors <= '0;
                  converged   <= 1'b0;
               end
            end
            PRESENT: begin
               if (hold_end) begin
                  hold <= '0;
                  if (mismatch && err != ERR_MAX) err <= err + ERR_ONE;
                  if (!last_idx) idx <= idx + IDX_ONE;
               end else begin
                  hold <= hold + 4'd1;
               end
            end
            EPOCH_END: begin
               last_errors <= err;
               epoch_count <= epoch_count + 8'd1;
               if (err == '0) begin
                  converged <= 1'b1;
               end else if (epoch_limit) begin
                  converged <= 1'b0;
               end else begin
                  err  <= '0;
                  idx  <= '0;
                  hold <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: a behavioural perceptron stub answers on p_out, a
// scoreboard queue holds the expected end-of-run results pushed when start is driven.
module tb_perceptron_trainer;
   localparam int ADDR_W    = 3;
   localparam int HOLD      = 2;
   localparam int MAXE      = 4;
   localparam int N         = 2 ** ADDR_W;
   localparam int EPOCH_LEN = N * HOLD + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              load_valid = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [3:0]        load_in1 = '0;
   logic [3:0]        load_in2 = '0;
   logic [6:0]        load_in3 = '0;
   logic              load_label = 1'b0;
   logic              start = 1'b0;
   logic              p_out;
   logic [3:0]        p_in1, p_in2;
   logic [6:0]        p_in3;
   logic              p_desired, busy, done, converged;
   logic [7:0]        epoch_count;
   logic [ADDR_W:0]   last_errors;

   int          checks = 0;
   int          errors = 0;
   int          stub_mode = 1;  // 0 perfect, 1 stuck at 0, 2 learning
   int          flip_cycles;
   logic [15:0] flip_word;
   logic [15:0] model_mem [N];
   logic [31:0] exp_q [$];

   perceptron_trainer #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD), .MAX_EPOCHS(MAXE)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
      .load_in1(load_in1), .load_in2(load_in2), .load_in3(load_in3),
      .load_label(load_label), .start(start), .p_out(p_out),
      .p_in1(p_in1), .p_in2(p_in2), .p_in3(p_in3), .p_desired(p_desired),
      .busy(busy), .done(done), .converged(converged),
      .epoch_count(epoch_count), .last_errors(last_errors)
   );

   always #5 clk = ~clk;

   // Perceptron stub: registered output; the learning stub misclassifies sample 5 for two epochs.
   always @(posedge clk) begin
      if (stub_mode != 2) flip_cycles <= 0;
      if (stub_mode == 1) begin
         p_out <= 1'b0;
      end else if (stub_mode == 2 && busy && flip_cycles < 2 * HOLD &&
                   {p_in1, p_in2, p_in3, p_desired} == flip_word) begin
         p_out       <= ~p_desired;
         flip_cycles <= flip_cycles + 1;
      end else begin
         p_out <= p_desired;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_exp(input int lat, input bit conv, input int ep, input int er);
      return {16'(lat), 3'b0, conv, 8'(ep), 4'(er)};
   endfunction

   function automatic logic [15:0] sample_word(input int k);
      logic [7:0] labels;
      labels = 8'b0010_0110;
      return {4'(k), 4'(15 - k), 7'(k * 9 + 3), labels[k]};
   endfunction

   task automatic load(input int a, input logic [15:0] w);
      load_valid = 1'b1;
      load_addr  = ADDR_W'(a);
      {load_in1, load_in2, load_in3, load_label} = w;
      @(negedge clk);
      load_valid   = 1'b0;
      model_mem[a] = w;
   endtask

   task automatic load_all();
      for (int k = 0; k < N; k++) load(k, sample_word(k));
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_p"}, 32'({p_in1, p_in2, p_in3, p_desired}), 32'd0);
   endtask

   task automatic run(input int mode, input logic [31:0] exp_res, input bit intrude,
                      input bit co_load, input logic [15:0] co_word);
      int        lat;
      bit        got;
      logic [31:0] e;
      stub_mode = mode;
      start     = 1'b1;
      if (co_load) begin
         load_valid = 1'b1;
         load_addr  = '0;
         {load_in1, load_in2, load_in3, load_label} = co_word;
         model_mem[0] = co_word;
      end
      exp_q.push_back(exp_res);
      @(negedge clk);
      start      = 1'b0;
      load_valid = 1'b0;
      lat = 1;
      got = 0;
      while (lat < 400 && !got) begin
         if (intrude && lat == 4) begin
            start      = 1'b0;
            load_valid = 1'b0;
         end
         if (lat == 1) check("busy_after_start", 32'(busy), 32'd1);
         if (lat <= N * HOLD && (lat - 1) % HOLD == 0)
            check($sformatf("present_s%0d", (lat - 1) / HOLD),
                  32'({p_in1, p_in2, p_in3, p_desired}), 32'(model_mem[(lat - 1) / HOLD]));
         if (intrude && lat == 3) begin
            start      = 1'b1;
            load_valid = 1'b1;
            load_addr  = 3'd2;
            {load_in1, load_in2, load_in3, load_label} = ~model_mem[2];
         end
         if (done) got = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      start      = 1'b0;
      load_valid = 1'b0;
      if (!got) check("done_timeout", 32'd0, 32'd1);
      e = exp_q.pop_front();
      check("latency", 32'(lat), 32'(e[31:16]));
      check("converged", 32'(converged), 32'(e[12]));
      check("epoch_count", 32'(epoch_count), 32'(e[11:4]));
      check("last_errors", 32'(last_errors), 32'(e[3:0]));
      check_quiet("done_state");
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < N; k++) model_mem[k] = '0;
      // Reset held while start and a load are driven.
      @(negedge clk);
      start      = 1'b1;
      load_valid = 1'b1;
      load_addr  = 3'd3;
      {load_in1, load_in2, load_in3, load_label} = 16'hFFFF;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      check("reset_done", 32'(done), 32'd0);
      check("reset_epochs", 32'(epoch_count), 32'd0);
      check("reset_lasterr", 32'(last_errors), 32'd0);
      check("reset_conv", 32'(converged), 32'd0);
      start      = 1'b0;
      load_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      check_quiet("idle");

      // Zeroed memory, stuck stub: every label 0 so the first epoch converges.
      run(1, mk_exp(N * HOLD + 2, 1, 1, 0), 0, 0, '0);

      load_all();
      flip_word = sample_word(5);
      run(0, mk_exp(N * HOLD + 2, 1, 1, 0), 0, 0, '0);
      run(1, mk_exp(MAXE * EPOCH_LEN + 1, 0, MAXE, 3), 0, 0, '0);
      run(2, mk_exp(3 * EPOCH_LEN + 1, 1, 3, 0), 0, 0, '0);
      run(0, mk_exp(N * HOLD + 2, 1, 1, 0), 1, 0, '0);
      run(0, mk_exp(N * HOLD + 2, 1, 1, 0), 0, 1, 16'hA5C3);

      // Reset while sample 4 is on the outputs.
      stub_mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_idx4", 32'({p_in1, p_in2, p_in3, p_desired}), 32'(model_mem[4]));
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_quiet("mid_reset");
      check("mid_epochs", 32'(epoch_count), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_conv", 32'(converged), 32'd0);
      for (int k = 0; k < N; k++) model_mem[k] = '0;
      @(negedge clk);
      run(1, mk_exp(N * HOLD + 2, 1, 1, 0), 0, 0, '0);
      load_all();
      run(0, mk_exp(N * HOLD + 2, 1, 1, 0), 0, 0, '0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Training sequencer that sits directly upstream of the perceptron stage. It stores a small labelled sample set and presents each sample to the perceptron's `in1`/`in2`/`in3`/`desired_out` inputs, one epoch after another. It checks the perceptron's registered `out` against each label and counts misclassifications per epoch. It stops when an epoch completes with zero errors (converged) or when the epoch limit is reached.

## Interface
- `ADDR_W`, 3, sample-address width; the set holds NUM_SAMPLES = 2**ADDR_W entries.
- `HOLD_CYCLES`, 2, cycles each sample is held on the perceptron inputs; legal range 2..15.
- `MAX_EPOCHS`, 64, epoch limit; legal range 1..255.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  write one sample this cycle.
- `load_addr`  in  ADDR_W  sample slot to write.
- `load_in1`  in  4  feature 1.
- `load_in2`  in  4  feature 2.
- `load_in3`  in  7  feature 3.
- `load_label`  in  1  desired classification.
- `start`  in  1  begin training; single-cycle pulse or level.
- `p_out`  in  1  perceptron registered output.
- `p_in1`  out  4  feature 1 to the perceptron.
- `p_in2`  out  4  feature 2 to the perceptron.
- `p_in3`  out  7  feature 3 to the perceptron.
- `p_desired`  out  1  label to the perceptron.
- `busy`  out  1  high in PRESENT and EPOCH_END.
- `done`  out  1  high in DONE.
- `converged`  out  1  valid while `done`.
- `epoch_count`  out  8  number of epochs completed.
- `last_errors`  out  ADDR_W+1  error count of the most recent completed epoch.

## Operation
- Sample memory: NUM_SAMPLES × 16 bits (4+4+7+1), registered.
  - Cleared to zero by reset.
  - Written on `load_valid` only in IDLE or DONE; writes in any other state are ignored.
- State machine: IDLE, PRESENT, EPOCH_END, DONE.
- IDLE:
  - All `p_*` outputs are 0.
  - `start` moves to PRESENT with idx=0, hold=0, err=0, `epoch_count`=0.
- PRESENT:
  - `p_*` outputs = mem[idx].
  - hold counts 0..HOLD_CYCLES-1.
  - When hold==HOLD_CYCLES-1: compare `p_out` with mem[idx].label; err += 1 on mismatch.
  - If idx is the last entry, go to EPOCH_END; otherwise idx += 1 and hold = 0.
- EPOCH_END (1 cycle):
  - `p_*` outputs hold the last sample.
  - `last_errors` ← err; `epoch_count` += 1.
  - err==0: go to DONE with `converged`=1.
  - Else if `epoch_count`+1 == MAX_EPOCHS: go to DONE with `converged`=0.
  - Else: err=0, idx=0, hold=0, go to PRESENT.
- DONE:
  - `p_*` outputs are 0.
  - Results hold until `start`, which restarts exactly as from IDLE (counters cleared, memory kept).
- `start` in PRESENT or EPOCH_END is ignored.
- Widths:
  - err saturates at NUM_SAMPLES; this cannot overflow in ADDR_W+1 bits.
  - `epoch_count` never exceeds MAX_EPOCHS.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - `epoch_count`=0, `last_errors`=0, `converged`=0.
  - Memory zeroed.
- Reset asserted mid-operation: on the next edge all of the above take their reset values; any partial epoch is discarded.
- `start` sampled at edge T: `busy`=1 and `p_*`=sample 0 from T+1.
- Each sample is held for HOLD_CYCLES cycles. The perceptron registers `out` one cycle after its inputs change, so `p_out` is sampled in the sample's final hold cycle (minimum HOLD_CYCLES=2).
- Epoch length: NUM_SAMPLES·HOLD_CYCLES + 1 cycles.
- Converged on the first epoch: `done`=1 at T + NUM_SAMPLES·HOLD_CYCLES + 2.
- Simultaneous `load_valid` and `start` in IDLE/DONE: the write takes effect, and the first presentation (one cycle later) sees the new data.
- Samples are presented in address order 0..NUM_SAMPLES-1 each epoch; idx wraps only through EPOCH_END.

## Test plan
- Reset: hold `reset`=0 for 2 cycles while driving `start`/`load_valid` → all outputs 0, `busy`=0, memory reads zero after release.
- Perfect classifier stub (`p_out` = the label presented on the previous cycle), 8 samples loaded, defaults → `done` 18 cycles after `start`, `converged`=1, `epoch_count`=1, `last_errors`=0.
- Stuck stub (`p_out`=0), three labels =1, MAX_EPOCHS=4 → `done` with `converged`=0, `epoch_count`=4, `last_errors`=3.
- Learning stub (wrong on sample 5 for 2 epochs, then correct) → `converged`=1, `epoch_count`=3, `last_errors`=0.
- Busy protection: `load_valid` to addr 2 and a second `start` during PRESENT → memory unchanged, epoch sequence and counts unaffected.
- Reset mid-epoch (idx=4): next cycle IDLE, `busy`=0, `epoch_count`=0, memory zero; a restart after reloading behaves as in the perfect-classifier scenario.
